// File: rtl/id_issue_sb.sv
// rtl/id_issue_sb.sv - ID-stage decoder with registered ID/EX issue stage and pending-write scoreboard
module id_issue_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int CNT_WIDTH  = 2,
  localparam int REG_AW    = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [31:0]           in_inst,
  output logic                  reg_read_en_1,
  output logic                  reg_read_en_2,
  output logic [REG_AW-1:0]     reg_addr_1,
  output logic [REG_AW-1:0]     reg_addr_2,
  input  logic [DATA_WIDTH-1:0] reg_data_1,
  input  logic [DATA_WIDTH-1:0] reg_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [5:0]            out_funct,
  output logic [DATA_WIDTH-1:0] out_operand_1,
  output logic [DATA_WIDTH-1:0] out_operand_2,
  output logic [4:0]            out_shamt,
  output logic                  out_write_reg_en,
  output logic [REG_AW-1:0]     out_write_reg_addr,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic                  flush
);

  localparam logic [CNT_WIDTH-1:0] SAT = '1;

  logic [5:0]            op;
  logic [REG_AW-1:0]     rs, rt, rd;
  logic [15:0]           imm;

  logic                  d_rd1, d_rd2, d_wr, d_we;
  logic [REG_AW-1:0]     d_dst;
  logic [5:0]            d_funct;
  logic [4:0]            d_shamt;
  logic [DATA_WIDTH-1:0] d_op1, d_op2;

  logic [CNT_WIDTH-1:0]  pending [REG_NUM];
  logic [REG_NUM-1:0]    inc_vec, dec_vec;
  logic                  hazard, fire;

  assign op  = in_inst[31:26];
  assign rs  = REG_AW'(in_inst[25:21]);
  assign rt  = REG_AW'(in_inst[20:16]);
  assign rd  = REG_AW'(in_inst[15:11]);
  assign imm = in_inst[15:0];

  // Instruction decode; everything reads as a NOP when IF has nothing valid
  always_comb begin
    d_rd1   = 1'b0;
    d_rd2   = 1'b0;
    d_wr    = 1'b0;
    d_dst   = '0;
    d_funct = '0;
    d_shamt = '0;
    d_op1   = '0;
    d_op2   = '0;
    if (in_valid) begin
      case (op)
        6'b000000: begin
          d_rd1   = (rs != '0);
          d_rd2   = (rt != '0);
          d_wr    = 1'b1;
          d_dst   = rd;
          d_funct = in_inst[5:0];
          d_shamt = in_inst[10:6];
          d_op1   = reg_data_1;
          d_op2   = reg_data_2;
        end
        6'b001100, 6'b001101, 6'b001110: begin
          // ANDI/ORI/XORI map onto the AND/OR/XOR ALU functions 1001xx
          d_rd1   = (rs != '0);
          d_wr    = 1'b1;
          d_dst   = rt;
          d_funct = {4'b1001, op[1:0]};
          d_op1   = reg_data_1;
          d_op2   = DATA_WIDTH'(imm);
        end
        6'b001111: begin
          // LUI is issued as OR of zero with the shifted immediate
          d_wr    = 1'b1;
          d_dst   = rt;
          d_funct = 6'b100101;
          d_op2   = DATA_WIDTH'({imm, 16'h0000});
        end
        default: ;
      endcase
    end
  end

  assign d_we          = d_wr && (d_dst != '0);
  assign reg_read_en_1 = d_rd1;
  assign reg_read_en_2 = d_rd2;
  assign reg_addr_1    = d_rd1 ? rs : '0;
  assign reg_addr_2    = d_rd2 ? rt : '0;

  // Stall on a pending source, or a destination whose counter cannot count further
  always_comb begin
    hazard = 1'b0;
    if (d_rd1 && (pending[rs] != '0)) hazard = 1'b1;
    if (d_rd2 && (pending[rt] != '0)) hazard = 1'b1;
    if (d_we && (pending[d_dst] == SAT)) hazard = 1'b1;
  end

  assign in_ready = rst && !flush && !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  // Per-register increment (issue) and decrement (retire) strobes
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (fire && d_we) inc_vec[d_dst] = 1'b1;
    if (wb_en && (wb_addr != '0)) dec_vec[wb_addr] = 1'b1;
  end

  // Pending-write counters; simultaneous issue and retire on one register cancel
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (!rst || flush) begin
        pending[i] <= '0;
      end else begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   pending[i] <= pending[i] + CNT_WIDTH'(1);
          2'b01:   if (pending[i] != '0) pending[i] <= pending[i] - CNT_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

  // ID/EX output register; payload holds while EX back-pressures
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid          <= 1'b0;
      out_addr           <= '0;
      out_funct          <= '0;
      out_operand_1      <= '0;
      out_operand_2      <= '0;
      out_shamt          <= '0;
      out_write_reg_en   <= 1'b0;
      out_write_reg_addr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid          <= 1'b1;
      out_addr           <= in_addr;
      out_funct          <= d_funct;
      out_operand_1      <= d_op1;
      out_operand_2      <= d_op2;
      out_shamt          <= d_shamt;
      out_write_reg_en   <= d_we;
      out_write_reg_addr <= d_dst;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_issue_sb.md
Name: id_issue_sb

Overview:
- Parametrised successor to the combinational R-type decoder in the ID stage.
- Decodes SPECIAL (R-type) and logical-immediate I-type instructions, then holds the result in a registered ID/EX output stage with a valid/ready handshake.
- A per-register pending-write scoreboard stalls RAW hazards until writeback, so variable-latency EX/MEM units can be used.
- Sits between the IF stage / RegReadProxy and the EX stage.

Parameters:
- DATA_WIDTH, 32, operand and register data width.
- ADDR_WIDTH, 32, instruction address width.
- REG_NUM, 32, number of architectural registers; REG_AW = clog2(REG_NUM).
- CNT_WIDTH, 2, width of each pending-write counter; saturation value is 2^CNT_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- in_addr  in  ADDR_WIDTH  instruction address.
- in_inst  in  32  instruction word.
- reg_read_en_1 / reg_read_en_2  out  1  regfile read enables (combinational).
- reg_addr_1 / reg_addr_2  out  REG_AW  regfile read addresses (combinational).
- reg_data_1 / reg_data_2  in  DATA_WIDTH  read data from RegReadProxy.
- out_valid  out  1  EX payload valid.
- out_ready  in  1  EX accepts the payload.
- out_addr  out  ADDR_WIDTH  instruction address.
- out_funct  out  6  ALU function.
- out_operand_1 / out_operand_2  out  DATA_WIDTH  operands.
- out_shamt  out  5  shift amount.
- out_write_reg_en  out  1  destination write enable.
- out_write_reg_addr  out  REG_AW  destination register.
- wb_en  in  1  writeback retire strobe.
- wb_addr  in  REG_AW  retiring destination register.
- flush  in  1  squash in-flight state.

Behaviour:
- Reset (rst==0 at clk edge): out_valid=0; all out_* fields=0; every pending counter=0. in_ready=0 while rst==0.
- Decode is combinational from in_inst and is gated by in_valid. When in_valid==0, read enables and addresses are 0.
- op=000000 (SPECIAL): read rs and rt; write rd; funct=inst[5:0]; shamt=inst[10:6]; op1=reg_data_1; op2=reg_data_2.
- op=001100 (ANDI), 001101 (ORI), 001110 (XORI): read rs only; write rt; funct=100100 / 100101 / 100110 respectively; op1=reg_data_1; op2=zero-extended imm; shamt=0.
- op=001111 (LUI): no read; write rt; funct=100101; op1=0; op2={imm,16'b0} truncated or zero-extended to DATA_WIDTH; shamt=0.
- Any other op: NOP. funct=000000, no reads, write disabled, all operands 0. It is still issued, so it occupies one slot.
- Register 0 is never read-enabled, never counted and never stalls. Destination 0 issues with write_reg_en=0.
- hazard = (any enabled source with pending!=0) OR (write-enabled destination with pending==saturation value).
- in_ready = rst && !flush && !hazard && (!out_valid || out_ready).
- fire = in_valid && in_ready. On fire, the output register loads the decoded payload with reg_data sampled in the same cycle, and out_valid becomes 1.
- When out_valid && out_ready && !fire, out_valid becomes 0. Issue latency is 1 cycle from fire to out_valid.
- While out_valid && !out_ready, all out_* fields hold stable.
- Scoreboard:
  - Fire with write enable and destination d≠0: pending[d]+1.
  - wb_en with wb_addr≠0: pending[wb_addr]-1.
  - Increment and decrement on the same register in the same cycle: no net change.
  - Decrement of a counter at 0 is ignored and the counter stays 0.
- RegReadProxy forwards same-cycle wb data. A source released by wb_en in cycle N may therefore fire in cycle N+1, not in cycle N, because hazard uses registered counters.
- flush (registered effect): out_valid=0 and all counters=0 at the next edge. Any fire is suppressed that cycle. wb_en is ignored in the flush cycle.
- Reset and flush take effect mid-stall with no residual state.

Test Plan:
1. ADDU $3,$1,$2 (0x00221821), in_valid=1, out_ready=1, no pending → in_ready=1; next cycle out_valid=1, funct=100001, write_reg_addr=3, op1/op2 equal the regfile data; pending[3]=1.
2. ORI $4,$3,0x00F0 issued one cycle after test 1 with no writeback → in_ready=0, and the stall persists. Pulse wb_en with wb_addr=3 in cycle N → in_ready=1 in cycle N+1; op2=0x000000F0; funct=100101.
3. LUI $5,0x1234 → no read enables; op2=0x12340000; op1=0; write_reg_addr=5.
4. out_ready=0 for 3 cycles after issue → out_* stay constant and in_ready=0; releasing out_ready=1 accepts the next instruction in the same cycle.
5. Issue three writes to $7 (CNT_WIDTH=2, saturation 3) with EX accepting each → the fourth write to $7 stalls. A wb_en to $7 in the same cycle as a fire to $7 leaves the count unchanged.
6. Assert flush with out_valid=1 and pending[3]=2 → next cycle out_valid=0 and pending all 0. A rst=0 pulse mid-stall → all outputs 0 and in_ready=0 during reset.
